vh_frame_sequencer: RTL and testbench
=====================================

Name: vh_frame_sequencer

Overview:
Frame-timing controller that sequences the pixel datapath for a programmed number of frames. It generates the active-region qualifiers (vsync, hsync, de), frame boundary pulses and a start/busy/done handshake. It replaces free-running sync generation in front of the BMP read/write models and pixel-processing blocks, where de drives read-enable and the 1-cycle-delayed de drives write-enable. A stall input freezes timing when downstream cannot accept pixels.

Parameters:
H_ACT, 2448, active pixels per line
H_BLK, 52, horizontal blanking clocks per line
V_ACT, 2048, active lines per frame
V_BLK, 122, blanking lines per frame
FRM_W, 8, width of frame-count request

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  start request, sampled only in IDLE
abort  in  1  terminate sequence, sampled in RUN
frm_num  in  FRM_W  frames to run, latched on accepted start; 0 = continuous until abort
stall  in  1  downstream hold; freezes counters while in RUN
vsync  out  1  high while vcnt < V_ACT
hsync  out  1  high while hcnt < H_ACT
de  out  1  vsync & hsync & ~stall_q (pixel valid)
frm_start  out  1  1-cycle pulse on first clock of each frame (hcnt=0, vcnt=0)
frm_end  out  1  1-cycle pulse on last clock of each frame (last blank clock)
frm_idx  out  FRM_W  index of the current frame, 0-based
hcnt  out  clog2(H_ACT+H_BLK)  horizontal position
vcnt  out  clog2(V_ACT+V_BLK)  line position
busy  out  1  high in RUN
done  out  1  1-cycle pulse on return to IDLE (normal completion or abort)

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0. Counters 0. The latched frame count is 0.
- States: IDLE, RUN. All outputs are registered.
- IDLE: start=1 & abort=0 at edge N:
  - state goes to RUN; frm_num is latched; hcnt=vcnt=frm_idx=0.
  - vsync, hsync, de, frm_start and busy are all 1 in the cycle following edge N. Latency is 1 clock.
- IDLE with start & abort in the same cycle: abort wins; the block stays in IDLE with no done pulse.
- RUN, stall=0, per clock:
  - hcnt increments and wraps at H_ACT+H_BLK-1 -> 0.
  - On the hcnt wrap, vcnt increments and wraps at V_ACT+V_BLK-1 -> 0.
  - On the vcnt wrap, frm_idx increments.
- RUN, stall=1:
  - hcnt, vcnt and frm_idx hold.
  - vsync and hsync hold; de=0.
  - frm_start and frm_end are suppressed and re-issued when the position advances.
  - A pixel position is never skipped or duplicated in de.
- frm_end: asserted on the clock where hcnt=H_ACT+H_BLK-1 and vcnt=V_ACT+V_BLK-1 with stall=0.
- Completion (frm_num≠0): on the frm_end clock of frame frm_num-1:
  - next state is IDLE; done=1 for one cycle; busy=0.
  - Counters return to 0; vsync, hsync and de are 0.
- Continuous (frm_num=0): frm_idx wraps at 2^FRM_W-1 -> 0; the block never self-terminates.
- abort in RUN: IDLE at the next edge. The done pulse, outputs and counters behave as in completion, mid-line included. abort overrides stall.
- start asserted during RUN: ignored, with no effect on the latched count.
- Back-to-back runs: start asserted during the done cycle is accepted, since the state is already IDLE. The next frame_start follows 1 clock later.
- Width rule: a parameter check fails elaboration if H_ACT, V_ACT or (H_BLK + V_BLK) equals 0.

Decomposition:
- Package vh_seq_pkg:
  - state encoding (IDLE=1'b0, RUN=1'b1)
  - clog2 function for counter widths
  - default timing constants for the 2448x2048 sensor
- One sub-module, vh_wrap_cnt:
  - parameterised up-counter with enable, synchronous clear and terminal-count output
  - instantiated twice: horizontal (enable = run & ~stall) and vertical (enable = horizontal terminal count)

Test Plan:
1. Single frame, H_ACT=4 H_BLK=2 V_ACT=3 V_BLK=1, frm_num=1 -> busy for 24 clocks, exactly 12 de cycles, 1 frm_start, 1 frm_end, done on clock 25 after start edge.
2. Multi-frame, frm_num=3, same timing -> 72 busy clocks, frm_idx 0,1,2, 36 de cycles total, 3 frm_start/frm_end pairs, single done.
3. Stall: 5-clock stall inserted at hcnt=2 vcnt=1 of frame 0 -> de low for those 5 clocks, hcnt/vcnt held, total busy 29 clocks, de count still 12.
4. Abort at hcnt=1 vcnt=2 of frame 1 (frm_num=3) -> next clock busy=0, vsync/hsync/de=0, done pulse, no further frm_end.
5. Continuous frm_num=0 with FRM_W=2 -> frm_idx sequence 0,1,2,3,0 across 5 frames; runs until abort; start during RUN ignored.
6. Reset assertion mid-line (rst_n low between edges) -> all outputs 0 immediately; start then abort in the same IDLE cycle -> stays IDLE, no done.

Source files
------------

// File: rtl/vh_seq_pkg.sv
// Shared types, timing defaults and width helper
// for the frame-timing sequencer.
package vh_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int H_ACT_DEF = 2448;
  localparam int H_BLK_DEF = 52;
  localparam int V_ACT_DEF = 2048;
  localparam int V_BLK_DEF = 122;
  localparam int FRM_W_DEF = 8;

  // Never returns less than 1 so a 1-deep counter still has a bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << w) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/vh_wrap_cnt.sv
// Up-counter with enable, synchronous clear and a
// terminal-count strobe that fires only on an enabled wrap.
module vh_wrap_cnt
  import vh_seq_pkg::*;
#(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt,
  output logic         tc
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  assign tc = en && (cnt_q == MAX_C);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign nxt = cnt_d;

endmodule

// File: rtl/vh_frame_sequencer.sv
// Frame-timing controller: sequences N frames of sync/de
// qualifiers with a start/busy/done handshake and stall hold.
module vh_frame_sequencer
  import vh_seq_pkg::*;
#(
  parameter int H_ACT = H_ACT_DEF,
  parameter int H_BLK = H_BLK_DEF,
  parameter int V_ACT = V_ACT_DEF,
  parameter int V_BLK = V_BLK_DEF,
  parameter int FRM_W = FRM_W_DEF,
  localparam int HW = clog2(H_ACT + H_BLK),
  localparam int VW = clog2(V_ACT + V_BLK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [FRM_W-1:0] frm_num,
  input  logic             stall,
  output logic             vsync,
  output logic             hsync,
  output logic             de,
  output logic             frm_start,
  output logic             frm_end,
  output logic [FRM_W-1:0] frm_idx,
  output logic [HW-1:0]    hcnt,
  output logic [VW-1:0]    vcnt,
  output logic             busy,
  output logic             done
);

  localparam int H_TOT = H_ACT + H_BLK;
  localparam int V_TOT = V_ACT + V_BLK;

  localparam logic [HW:0]   H_ACT_C = (HW+1)'(H_ACT);
  localparam logic [VW:0]   V_ACT_C = (VW+1)'(V_ACT);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);

  if (H_ACT == 0 || V_ACT == 0 || (H_BLK + V_BLK) == 0) begin : g_bad_timing
    $error("vh_frame_sequencer: degenerate timing parameters");
  end

  state_e state_q, state_d;

  logic [FRM_W-1:0] frm_num_q, frm_num_d;
  logic [FRM_W-1:0] frm_idx_q, frm_idx_d;
  logic             stall_q, stall_d;
  logic             vsync_q, vsync_d;
  logic             hsync_q, hsync_d;
  logic             de_q, de_d;
  logic             fs_q, fs_d;
  logic             fe_q, fe_d;
  logic             done_q, done_d;

  logic          run, run_d, accept, last_pos;
  logic          complete, quit;
  logic          h_en, h_clr, h_tc, v_tc;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;

  vh_wrap_cnt #(.MAX(H_TOT - 1), .W(HW)) u_hcnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (h_en),
    .clr  (h_clr),
    .cnt  (hcnt),
    .nxt  (h_nxt),
    .tc   (h_tc)
  );

  vh_wrap_cnt #(.MAX(V_TOT - 1), .W(VW)) u_vcnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (h_tc),
    .clr  (h_clr),
    .cnt  (vcnt),
    .nxt  (v_nxt),
    .tc   (v_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    run      = (state_q == RUN);
    accept   = !run && start && !abort;
    last_pos = (hcnt == H_LAST) && (vcnt == V_LAST);
    // A frm_num of zero never matches, giving continuous mode.
    complete = run && !abort && !stall && last_pos
               && (frm_num_q != '0)
               && (frm_idx_q == frm_num_q - 1'b1);
    quit     = run && (abort || complete);
    h_en     = run && !stall && !abort;
    h_clr    = accept || quit;
    state_d  = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (quit)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run_d     = (state_d == RUN);
    frm_num_d = accept ? frm_num : frm_num_q;
    frm_idx_d = frm_idx_q;
    if (h_clr)     frm_idx_d = '0;
    else if (v_tc) frm_idx_d = frm_idx_q + 1'b1;
    stall_d = run && run_d && stall;
    vsync_d = run_d && ({1'b0, v_nxt} < V_ACT_C);
    hsync_d = run_d && ({1'b0, h_nxt} < H_ACT_C);
    de_d    = vsync_d && hsync_d && !stall_d;
    fs_d    = run_d && !stall_d
              && (h_nxt == '0) && (v_nxt == '0);
    fe_d    = run_d && !stall_d
              && (h_nxt == H_LAST) && (v_nxt == V_LAST);
    done_d  = quit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_num_q <= '0;
      frm_idx_q <= '0;
      stall_q   <= 1'b0;
      vsync_q   <= 1'b0;
      hsync_q   <= 1'b0;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      fe_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      frm_num_q <= frm_num_d;
      frm_idx_q <= frm_idx_d;
      stall_q   <= stall_d;
      vsync_q   <= vsync_d;
      hsync_q   <= hsync_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      fe_q      <= fe_d;
      done_q    <= done_d;
    end
  end

  assign vsync     = vsync_q;
  assign hsync     = hsync_q;
  assign de        = de_q;
  assign frm_start = fs_q;
  assign frm_end   = fe_q;
  assign frm_idx   = frm_idx_q;
  assign busy      = run;
  assign done      = done_q;

endmodule

// File: tb/tb_vh_frame_sequencer.sv
// Randomised and directed bench for vh_frame_sequencer
// against a linear pixel-index reference model.
module tb_vh_frame_sequencer;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int VB = 1;
  localparam int FW = 2;
  localparam int HT = HA + HB;
  localparam int VT = VA + VB;
  localparam int FT = HT * VT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          stall = 1'b0;
  logic [FW-1:0] frm_num = '0;
  logic          vsync, hsync, de, frm_start, frm_end;
  logic          busy, done;
  logic [FW-1:0] frm_idx;
  logic [2:0]    hcnt;
  logic [1:0]    vcnt;
  logic [13:0]   obs;

  int checks = 0;
  int failures = 0;

  bit m_run = 0;
  int m_p = 0;
  bit m_st = 0;
  int m_nf = 0;
  bit m_done = 0;

  vh_frame_sequencer #(
    .H_ACT(HA), .H_BLK(HB), .V_ACT(VA),
    .V_BLK(VB), .FRM_W(FW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .frm_num  (frm_num),
    .stall    (stall),
    .vsync    (vsync),
    .hsync    (hsync),
    .de       (de),
    .frm_start(frm_start),
    .frm_end  (frm_end),
    .frm_idx  (frm_idx),
    .hcnt     (hcnt),
    .vcnt     (vcnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  assign obs = {busy, done, vsync, hsync, de, frm_start,
                frm_end, frm_idx, hcnt, vcnt};

  // Position is a flat pixel count since start; h/v/frame fall out of it.
  function automatic logic [13:0] exp_vec();
    logic [2:0] h;
    logic [1:0] v, ix;
    logic vs, hs, de_e, fs, fe;
    if (!m_run) return {1'b0, m_done, 12'd0};
    h    = 3'(m_p % HT);
    v    = 2'((m_p / HT) % VT);
    ix   = 2'(m_p / FT);
    vs   = (int'(v) < VA);
    hs   = (int'(h) < HA);
    de_e = vs && hs && !m_st;
    fs   = (h == 3'd0) && (v == 2'd0) && !m_st;
    fe   = ((m_p % FT) == FT - 1) && !m_st;
    return {1'b1, 1'b0, vs, hs, de_e, fs, fe, ix, h, v};
  endfunction

  task automatic tick(input logic s, input logic a,
                      input logic st, input logic [FW-1:0] fn);
    start = s;
    abort = a;
    stall = st;
    frm_num = fn;
    @(posedge clk);
    m_done = 0;
    if (!m_run) begin
      if (s && !a) begin
        m_run = 1; m_p = 0; m_st = 0; m_nf = int'(fn);
      end
    end else if (a) begin
      m_run = 0; m_done = 1;
    end else if (st) begin
      m_st = 1;
    end else if (m_nf != 0 && m_p == m_nf * FT - 1) begin
      m_run = 0; m_done = 1;
    end else begin
      m_p++; m_st = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (obs !== 14'd0) begin
      failures++;
      $display("FAIL reset: got=%h want=%h", obs, 14'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_run = 0; m_done = 0;
  endtask

  task automatic test_single();
    int busy_n = 0, de_n = 0, fs_n = 0, fe_n = 0, done_at = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      tick(i == 1, 1'b0, 1'b0, 2'd1);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL single t%0d: got=%h want=%h", i, obs, exp_vec());
      end
      busy_n += int'(busy); de_n += int'(de);
      fs_n += int'(frm_start); fe_n += int'(frm_end);
      if (done) done_at = i;
    end
    checks++;
    if (busy_n != 24 || de_n != 12) begin
      failures++;
      $display("FAIL single counts: busy=%0d de=%0d want 24 12", busy_n, de_n);
    end
    checks++;
    if (fs_n != 1 || fe_n != 1 || done_at != 25) begin
      failures++;
      $display("FAIL single pulses: fs=%0d fe=%0d done_at=%0d want 1 1 25",
               fs_n, fe_n, done_at);
    end
  endtask

  task automatic test_multi();
    int busy_n = 0, de_n = 0, fe_n = 0, done_n = 0;
    int idxq[$];
    for (int i = 1; i <= 90 && done_n == 0; i++) begin
      tick(i == 1, 1'b0, 1'b0, 2'd3);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL multi t%0d: got=%h want=%h", i, obs, exp_vec());
      end
      busy_n += int'(busy); de_n += int'(de);
      fe_n += int'(frm_end); done_n += int'(done);
      if (frm_start) idxq.push_back(int'(frm_idx));
    end
    checks++;
    if (busy_n != 72 || de_n != 36 || fe_n != 3 || done_n != 1) begin
      failures++;
      $display("FAIL multi counts: busy=%0d de=%0d fe=%0d done=%0d want 72 36 3 1",
               busy_n, de_n, fe_n, done_n);
    end
    checks++;
    if (idxq.size() != 3 || idxq[0] != 0 || idxq[1] != 1 || idxq[2] != 2) begin
      failures++;
      $display("FAIL multi idx: got %p want 0,1,2", idxq);
    end
  endtask

  task automatic test_stall();
    int busy_n = 0, de_n = 0, rem = 0, done_n = 0;
    bit fired = 0;
    for (int i = 1; i <= 50 && done_n == 0; i++) begin
      tick(i == 1, 1'b0, rem > 0, 2'd1);
      if (rem > 0) rem--;
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL stall t%0d: got=%h want=%h", i, obs, exp_vec());
      end
      busy_n += int'(busy); de_n += int'(de); done_n += int'(done);
      if (busy && hcnt == 3'd2 && vcnt == 2'd1 && !fired) begin
        fired = 1; rem = 5;
      end
    end
    checks++;
    if (busy_n != 29 || de_n != 12 || !fired) begin
      failures++;
      $display("FAIL stall counts: busy=%0d de=%0d fired=%0d want 29 12 1",
               busy_n, de_n, fired);
    end
  endtask

  task automatic test_abort();
    bit hit = 0;
    int fe_after = 0;
    for (int i = 1; i <= 60 && !hit; i++) begin
      tick(i == 1, 1'b0, 1'b0, 2'd3);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL abort run t%0d: got=%h want=%h", i, obs, exp_vec());
      end
      if (busy && frm_idx == 2'd1 && hcnt == 3'd1 && vcnt == 2'd2) hit = 1;
    end
    tick(1'b0, 1'b1, 1'b1, 2'd0);
    checks++;
    if (!hit || {busy, done, vsync, hsync, de} !== 5'b01000) begin
      failures++;
      $display("FAIL abort edge: hit=%0d got=%b want 01000", hit,
               {busy, done, vsync, hsync, de});
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0, 2'd0);
      fe_after += int'(frm_end);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL abort idle t%0d: got=%h want=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (fe_after != 0) begin
      failures++;
      $display("FAIL abort fe: got=%0d want 0", fe_after);
    end
  endtask

  task automatic test_continuous();
    int idxq[$];
    for (int i = 1; i <= 120; i++) begin
      tick(i == 1 || (i % 7) == 0, 1'b0, 1'b0, i == 1 ? 2'd0 : 2'd1);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL cont t%0d: got=%h want=%h", i, obs, exp_vec());
      end
      if (frm_start) idxq.push_back(int'(frm_idx));
    end
    checks++;
    if (idxq.size() != 5 || idxq[0] != 0 || idxq[1] != 1 || idxq[2] != 2
        || idxq[3] != 3 || idxq[4] != 0) begin
      failures++;
      $display("FAIL cont idx: got %p want 0,1,2,3,0", idxq);
    end
    tick(1'b0, 1'b1, 1'b0, 2'd0);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL cont abort: busy=%b done=%b want 0 1", busy, done);
    end
  endtask

  task automatic test_reset_midline();
    for (int i = 1; i <= 10; i++) tick(i == 1, 1'b0, 1'b0, 2'd2);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 14'd0) begin
      failures++;
      $display("FAIL midreset: got=%h want=%h", obs, 14'd0);
    end
    m_run = 0; m_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(i == 0, i == 0, 1'b0, 2'd1);
      checks++;
      if (obs !== exp_vec() || busy || done) begin
        failures++;
        $display("FAIL start+abort t%0d: got=%h want=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick(($urandom % 4) == 0, ($urandom % 50) == 0,
           ($urandom % 5) == 0, 2'($urandom));
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random t%0d: got=%h want=%h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_abort();
    test_continuous();
    test_reset_midline();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
